// File: rtl/regfile_write_bank.sv
// Write side of the integer register file: one-hot write decode, a one-entry
// pending stage exposed for forwarding, and the flop-based storage array.
module regfile_write_bank #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_rd_wren,
    input  logic [ADDR_W-1:0]      i_rd_addr,
    input  logic [DATA_W-1:0]      i_rd_data,
    output logic [NREG-1:0]        o_wr_onehot,
    output logic                   o_pend_valid,
    output logic [ADDR_W-1:0]      o_pend_addr,
    output logic [DATA_W-1:0]      o_pend_data,
    output logic                   o_wr_commit,
    output logic [NREG*DATA_W-1:0] o_regs,
    output logic [CNT_W-1:0]       o_commit_cnt
);

    logic                   acc_s;
    logic [NREG-1:0]        onehot_s;
    logic [NREG-1:0]        commit_sel_s;
    logic                   pend_valid_q;
    logic [ADDR_W-1:0]      pend_addr_q;
    logic [DATA_W-1:0]      pend_data_q;
    logic [ADDR_W-1:0]      pend_addr_d;
    logic [DATA_W-1:0]      pend_data_d;
    logic                   wr_commit_q;
    logic [CNT_W-1:0]       commit_cnt_q;
    logic [CNT_W-1:0]       commit_cnt_d;

    // Request acceptance; x0 writes are dropped here so they never reach pending
    always_comb begin
        acc_s = 1'b0;
        if (i_rd_wren && (i_rd_addr != {ADDR_W{1'b0}})) begin
            acc_s = 1'b1;
        end else begin
            acc_s = 1'b0;
        end
    end

    // One-hot decode of the accepted request, forced quiet while reset is held
    always_comb begin
        onehot_s = {NREG{1'b0}};
        if (acc_s && i_reset) begin
            onehot_s[i_rd_addr] = 1'b1;
        end else begin
            onehot_s = {NREG{1'b0}};
        end
    end

    // Next pending payload: capture on accept, otherwise hold
    always_comb begin
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        if (acc_s) begin
            pend_addr_d = i_rd_addr;
            pend_data_d = i_rd_data;
        end else begin
            pend_addr_d = pend_addr_q;
            pend_data_d = pend_data_q;
        end
    end

    // Saturating commit counter next state
    always_comb begin
        commit_cnt_d = commit_cnt_q;
        if (pend_valid_q && (commit_cnt_q != {CNT_W{1'b1}})) begin
            commit_cnt_d = commit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            commit_cnt_d = commit_cnt_q;
        end
    end

    // Commit select: decode of the pending entry, bit 0 never set
    always_comb begin
        commit_sel_s = {NREG{1'b0}};
        if (pend_valid_q) begin
            commit_sel_s[pend_addr_q] = 1'b1;
            commit_sel_s[0]           = 1'b0;
        end else begin
            commit_sel_s = {NREG{1'b0}};
        end
    end

    // Pending stage, commit pulse and counter; reset discards any in-flight write
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= {ADDR_W{1'b0}};
            pend_data_q  <= {DATA_W{1'b0}};
            wr_commit_q  <= 1'b0;
            commit_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pend_valid_q <= acc_s;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            wr_commit_q  <= pend_valid_q;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign o_regs[DATA_W-1:0] = {DATA_W{1'b0}};

    for (genvar k = 1; k < NREG; k++) begin : g_reg
        logic [DATA_W-1:0] reg_q;
        logic [DATA_W-1:0] reg_d;

        // Register k takes the pending data only when the pending entry targets it
        always_comb begin
            reg_d = reg_q;
            if (commit_sel_s[k]) begin
                reg_d = pend_data_q;
            end else begin
                reg_d = reg_q;
            end
        end

        // Storage flop for register k
        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                reg_q <= {DATA_W{1'b0}};
            end else begin
                reg_q <= reg_d;
            end
        end

        assign o_regs[DATA_W*k +: DATA_W] = reg_q;
    end

    assign o_wr_onehot  = onehot_s;
    assign o_pend_valid = pend_valid_q;
    assign o_pend_addr  = pend_addr_q;
    assign o_pend_data  = pend_data_q;
    assign o_wr_commit  = wr_commit_q;
    assign o_commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_regfile_write_bank.sv
// Randomized bench for regfile_write_bank against a queue-based reference model.
module tb_regfile_write_bank;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst_n;
    logic                   rd_wren;
    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic [NREG-1:0]        wr_onehot;
    logic                   pend_valid;
    logic [ADDR_W-1:0]      pend_addr;
    logic [DATA_W-1:0]      pend_data;
    logic                   wr_commit;
    logic [NREG*DATA_W-1:0] regs;
    logic [CNT_W-1:0]       commit_cnt;

    regfile_write_bank #(
        .DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rd_wren    (rd_wren),
        .i_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .o_wr_onehot  (wr_onehot),
        .o_pend_valid (pend_valid),
        .o_pend_addr  (pend_addr),
        .o_pend_data  (pend_data),
        .o_wr_commit  (wr_commit),
        .o_regs       (regs),
        .o_commit_cnt (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    int unsigned       n_checks = 0;
    int unsigned       n_errors = 0;
    logic [DATA_W-1:0] m_regs [NREG];
    wr_t               m_pq [$];
    int                m_cnt;
    logic              m_commit;
    logic [ADDR_W-1:0] m_last_a;
    logic [DATA_W-1:0] m_last_d;

    task automatic check_eq(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG*DATA_W-1:0] model_flat();
        logic [NREG*DATA_W-1:0] f;
        f = '0;
        for (int k = 0; k < NREG; k++) f[DATA_W*k +: DATA_W] = m_regs[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_regs[k] = '0;
        m_pq.delete();
        m_cnt    = 0;
        m_commit = 1'b0;
        m_last_a = '0;
        m_last_d = '0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".pend_valid"}, pend_valid, (m_pq.size() > 0));
        check_eq({tag, ".pend_addr"}, pend_addr, m_last_a);
        check_eq({tag, ".pend_data"}, pend_data, m_last_d);
        check_eq({tag, ".commit"}, wr_commit, m_commit);
        check_eq({tag, ".cnt"}, commit_cnt, m_cnt);
        check_eq({tag, ".regs"}, regs, model_flat());
    endtask

    // One clock of stimulus: drive at negedge, check onehot, then model the edge and check state
    task automatic step(input string tag, input logic wren, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data);
        logic acc;
        logic [NREG-1:0] exp_oh;
        wr_t w;
        @(negedge clk);
        rd_wren = wren;
        rd_addr = addr;
        rd_data = data;
        acc = wren && (addr != 0);
        exp_oh = acc ? (32'd1 << addr) : 32'd0;
        #1;
        check_eq({tag, ".onehot"}, wr_onehot, exp_oh);
        @(posedge clk);
        m_commit = 1'b0;
        if (m_pq.size() > 0) begin
            w = m_pq.pop_front();
            m_regs[w.a] = w.d;
            if (m_cnt < CNT_MAX) m_cnt++;
            m_commit = 1'b1;
        end
        if (acc) begin
            m_pq.push_back({addr, data});
            m_last_a = addr;
            m_last_d = data;
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_wren = 1'b1;
        rd_addr = 5'd5;
        rd_data = 32'hDEADBEEF;
        model_reset();

        // Reset held for 3 cycles with an active request on the inputs
        #1;
        check_eq("rst.onehot", wr_onehot, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_state("rst");
        check_eq("rst.onehot2", wr_onehot, 32'd0);
        @(negedge clk);
        rd_wren = 1'b0;
        rst_n   = 1'b1;

        // Single write
        step("w5", 1'b1, 5'd5, 32'hDEADBEEF);
        step("w5+1", 1'b0, 5'd0, 32'h0);
        step("w5+2", 1'b0, 5'd0, 32'h0);

        // x0 write is dropped
        step("x0", 1'b1, 5'd0, 32'hFFFFFFFF);
        step("x0+1", 1'b0, 5'd0, 32'h0);

        // Ignored address/data when wren is low
        step("nowr", 1'b0, 5'd12, 32'h12345678);

        // Back-to-back same address
        step("b2b1", 1'b1, 5'd7, 32'h1);
        step("b2b2", 1'b1, 5'd7, 32'h2);
        step("b2b3", 1'b1, 5'd7, 32'h3);
        step("b2b4", 1'b0, 5'd0, 32'h0);
        step("b2b5", 1'b0, 5'd0, 32'h0);

        // Reset mid-operation while a write is pending
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("rstA");
        @(negedge clk);
        rst_n = 1'b1;
        step("mid", 1'b1, 5'd9, 32'h55);
        #1;
        rst_n   = 1'b0;
        rd_wren = 1'b0;
        #1;
        model_reset();
        check_state("mid.rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("mid+1", 1'b0, 5'd0, 32'h0);
        step("mid+2", 1'b0, 5'd0, 32'h0);

        // Counter saturation: 20 writes to x1
        for (int i = 0; i < 20; i++) step("sat", 1'b1, 5'd1, 32'hA000_0000 + i);
        step("sat+1", 1'b0, 5'd0, 32'h0);
        step("sat+2", 1'b0, 5'd0, 32'h0);
        check_eq("sat.final_cnt", commit_cnt, 4'hF);
        check_eq("sat.reg1", regs[DATA_W +: DATA_W], 32'hA000_0013);

        // Fresh start, then randomized traffic biased toward address collisions
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [ADDR_W-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
            step("rnd", ($urandom_range(0, 3) != 0), a, $urandom);
        end
        step("rnd.end1", 1'b0, 5'd0, 32'h0);
        step("rnd.end2", 1'b0, 5'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the integer register file. The existing 32:1 read multiplexers consume this block's flattened register array.
- Accepts one write-back request per cycle, decodes rd into a one-hot write enable, and holds the request in a one-entry pending stage.
- Commits the pending entry to the 32-entry storage array on the following edge.
- Exposes the pending entry so the read side can forward it before commit.

Parameters:
- DATA_W, 32, width of each register.
- NREG, 32, number of architectural registers (x0..x31).
- ADDR_W, 5, width of the register address; must equal log2(NREG).
- CNT_W, 16, width of the commit counter.

Ports:
- i_clk  input  1  single clock; all state updates on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_rd_wren  input  1  write-back request valid this cycle.
- i_rd_addr  input  ADDR_W  destination register index.
- i_rd_data  input  DATA_W  write-back data.
- o_wr_onehot  output  NREG  combinational one-hot decode of the accepted request.
- o_pend_valid  output  1  pending stage holds an uncommitted write.
- o_pend_addr  output  ADDR_W  pending destination index.
- o_pend_data  output  DATA_W  pending data.
- o_wr_commit  output  1  one-cycle pulse; the array was updated on this edge.
- o_regs  output  NREG*DATA_W  flattened array; register k occupies bits [DATA_W*k+DATA_W-1 : DATA_W*k].
- o_commit_cnt  output  CNT_W  saturating count of committed writes.

Behaviour:
- Reset, asynchronous on falling i_reset, held while low:
  - all o_regs = 0
  - o_pend_valid = 0, o_pend_addr = 0, o_pend_data = 0
  - o_wr_commit = 0
  - o_commit_cnt = 0
  - An in-flight pending write is discarded and never commits.
- Accept condition: acc = i_rd_wren && (i_rd_addr != 0). Writes to x0 are silently dropped: no pending entry, no commit, no count.
- o_wr_onehot:
  - Pure combinational: bit i_rd_addr = 1 when acc, all other bits 0.
  - Bit 0 is always 0.
  - Outputs 0 during reset.
- Pending stage, every rising edge:
  - o_pend_valid <= acc.
  - When acc: o_pend_addr <= i_rd_addr, o_pend_data <= i_rd_data.
  - When not acc: addr/data hold their previous values; o_pend_valid qualifies them.
- Commit stage, same edge, using pending values from before the edge:
  - If o_pend_valid, register[o_pend_addr] <= o_pend_data.
  - o_wr_commit <= o_pend_valid.
  - o_commit_cnt increments by 1 when o_pend_valid, saturating at 2^CNT_W-1 (no wrap).
- Latency:
  - Request sampled at edge N appears on o_pend_* after edge N.
  - Data appears in o_regs after edge N+1.
  - o_wr_commit is high in the cycle following edge N+1.
- Back-to-back requests: one per cycle sustained, no stall, no ready signal. On each edge the new request enters pending while the old pending commits.
- Same address on consecutive cycles: both commit in order; the later value is final.
- Pending and commit target the same register on one edge: the array gets the old pending data; pending gets the new data.
- Register 0 in o_regs is constant 0 and is never written.
- o_regs is driven directly from flops, with no combinational path from inputs.
- i_rd_addr / i_rd_data are ignored when i_rd_wren = 0.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles with i_rd_wren=1, addr=5, data=0xDEADBEEF → o_regs all 0, o_pend_valid=0, o_commit_cnt=0, o_wr_onehot=0.
- Single write: after reset, wren=1, addr=5, data=0xDEADBEEF for 1 cycle:
  - o_wr_onehot=0x00000020 in that cycle.
  - o_pend_valid=1 / o_pend_addr=5 next cycle.
  - reg5=0xDEADBEEF and o_wr_commit=1 the cycle after.
  - o_commit_cnt=1.
- x0 write: wren=1, addr=0, data=0xFFFFFFFF → o_wr_onehot=0, o_pend_valid stays 0, reg0 stays 0, count unchanged.
- Back-to-back same address: addr=7 with data 0x1, 0x2, 0x3 on consecutive cycles:
  - o_wr_commit high 3 consecutive cycles.
  - reg7 reads 0x1, 0x2, 0x3 in successive cycles, ending at 0x3.
  - o_commit_cnt=3.
- Reset mid-operation: write addr=9, data=0x55 and assert i_reset=0 while o_pend_valid=1 → reg9 stays 0, o_wr_commit never pulses, count 0 after release.
- Saturation: with CNT_W=4, issue 20 consecutive writes to addr=1 → o_commit_cnt stops at 0xF and does not wrap; reg1 holds the last data.
